// File: rtl/uart_pkg.sv
// Shared UART definitions: default link rates, oversampling constants and the
// receiver state encoding. The transmitter imports the same package.
package uart_pkg;

  localparam int DEF_CLK_HZ = 100_000_000;
  localparam int DEF_BAUD   = 115_200;
  localparam int OVS        = 16;

  // Tick-counter values at which the line is sampled
  localparam logic [3:0] STRT_MID = 4'd7;
  localparam logic [3:0] BIT_END  = 4'd15;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Fractional-rate tick generator: one-cycle tick at an average rate of
// STEP/CLK_HZ per clock, phase-aligned by holding the accumulator in clear.
module uart_baud_tick #(
  parameter int CLK_HZ = 100_000_000,
  parameter int STEP   = 1_843_200
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic tick
);

  localparam logic [29:0] LIM = 30'(CLK_HZ);
  localparam logic [29:0] INC = 30'(STEP);

  logic [28:0] acc_q, acc_d;
  logic [29:0] sum;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    sum   = {1'b0, acc_q} + INC;
    tick  = 1'b0;
    acc_d = sum[28:0];
    if (clr) begin
      acc_d = '0;
    end else if (sum >= LIM) begin
      tick  = 1'b1;
      acc_d = 29'(sum - LIM);
    end
  end

  // NOTE: state registers use non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the line, validates the start bit, samples
// each bit at its centre and emits one-cycle data-valid / framing-error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ,
  parameter int BAUD   = DEF_BAUD
) (
  input  logic       sys_clk_i,
  input  logic       sys_rstn_i,
  input  logic       uart_rx_i,
  output logic [7:0] uart_dat_o,
  output logic       uart_vld_o,
  output logic       uart_ferr_o,
  output logic       uart_busy_o
);

  state_e      state_q, state_d;
  logic        meta_q, rxs_q;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shft_q, shft_d;
  logic [7:0]  dat_q, dat_d;
  logic        vld_q, vld_d;
  logic        ferr_q, ferr_d;
  logic        tick;

  uart_baud_tick #(
    .CLK_HZ (CLK_HZ),
    .STEP   (BAUD * OVS)
  ) u_tick (
    .clk  (sys_clk_i),
    .rstn (sys_rstn_i),
    .clr  (state_q == IDLE),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? cnt_q + 4'd1 : cnt_q;
    bit_d   = bit_q;
    shft_d  = shft_q;
    dat_d   = dat_q;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (tick && cnt_q == STRT_MID) begin
          if (rxs_q) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            cnt_d   = '0;
            bit_d   = '0;
          end
        end
      end
      DATA: begin
        // Line is LSB first; the wrap of cnt re-arms the next bit centre
        if (tick && cnt_q == BIT_END) begin
          shft_d = {rxs_q, shft_q[7:1]};
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tick && cnt_q == BIT_END) begin
          if (rxs_q) begin
            dat_d   = shft_q;
            vld_d   = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Synchronizer flops reset to the idle-high line level to avoid a false start
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      meta_q  <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shft_q  <= '0;
      dat_q   <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      meta_q  <= uart_rx_i;
      rxs_q   <= meta_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shft_q  <= shft_d;
      dat_q   <= dat_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
    end
  end

  assign uart_dat_o  = dat_q;
  assign uart_vld_o  = vld_q;
  assign uart_ferr_o = ferr_q;
  assign uart_busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: nominal frames, back-to-back frames, glitch
// rejection, framing error with break, mid-frame reset and +/-3% line rates.
module tb_uart_rx;

  localparam int BIT_NOM  = 868;
  localparam int BIT_FAST = 843;
  localparam int BIT_SLOW = 895;

  logic       clk;
  logic       rst_n;
  logic       line;
  logic [7:0] dat;
  logic       vld;
  logic       ferr;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int start_cyc;

  int         vld_cnt  = 0;
  int         ferr_cnt = 0;
  int         vld_cycq[$];
  logic [7:0] vld_datq[$];
  logic       prev_vld  = 1'b0;
  logic       prev_ferr = 1'b0;
  logic       wide_seen = 1'b0;
  logic       both_seen = 1'b0;

  uart_rx dut (
    .sys_clk_i   (clk),
    .sys_rstn_i  (rst_n),
    .uart_rx_i   (line),
    .uart_dat_o  (dat),
    .uart_vld_o  (vld),
    .uart_ferr_o (ferr),
    .uart_busy_o (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge away from DUT updates
  always @(negedge clk) begin
    if (vld) begin
      vld_cnt++;
      vld_cycq.push_back(cyc);
      vld_datq.push_back(dat);
    end
    if (ferr) ferr_cnt++;
    if ((vld && prev_vld) || (ferr && prev_ferr)) wide_seen = 1'b1;
    if (vld && ferr) both_seen = 1'b1;
    prev_vld  = vld;
    prev_ferr = ferr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input int n);
    line = v;
    idle(n);
  endtask

  task automatic send_byte(input logic [7:0] b, input int bit_clks, input logic stop_bit);
    start_cyc = cyc;
    drive_bit(1'b0, bit_clks);
    for (int i = 0; i < 8; i++) drive_bit(b[i], bit_clks);
    drive_bit(stop_bit, bit_clks);
  endtask

  initial begin
    int lat;
    int gap;
    int v0;
    int f0;

    line  = 1'b1;
    rst_n = 1'b0;
    idle(5);
    check("rst_dat",  dat,  8'h00);
    check("rst_vld",  vld,  1'b0);
    check("rst_ferr", ferr, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    idle(20);

    // Nominal 0xA5
    send_byte(8'hA5, BIT_NOM, 1'b1);
    check("a5_cnt",  vld_cnt, 1);
    check("a5_dat",  vld_datq[0], 8'hA5);
    check("a5_hold", dat, 8'hA5);
    lat = vld_cycq[0] - start_cyc;
    check("a5_lat_in_window", (lat >= 8235 && lat <= 8265), 1'b1);
    check("a5_busy", busy, 1'b0);
    idle(100);

    // Back-to-back 0x00 then 0xFF, no idle gap
    send_byte(8'h00, BIT_NOM, 1'b1);
    send_byte(8'hFF, BIT_NOM, 1'b1);
    check("b2b_cnt",  vld_cnt, 3);
    check("b2b_dat0", vld_datq[1], 8'h00);
    check("b2b_dat1", vld_datq[2], 8'hFF);
    gap = vld_cycq[2] - vld_cycq[1];
    check("b2b_gap_10bits", (gap >= 10 * BIT_NOM - 60 && gap <= 10 * BIT_NOM + 60), 1'b1);
    idle(200);

    // 200-clock low glitch: start check at ~434 clocks rejects it
    v0 = vld_cnt;
    f0 = ferr_cnt;
    drive_bit(1'b0, 200);
    line = 1'b1;
    idle(220);
    check("glitch_busy_420", busy, 1'b1);
    idle(40);
    check("glitch_idle_460", busy, 1'b0);
    check("glitch_no_vld",  vld_cnt,  v0);
    check("glitch_no_ferr", ferr_cnt, f0);
    idle(200);

    // 0x55 with stop bit 0, line held low two more bit times
    send_byte(8'h55, BIT_NOM, 1'b0);
    drive_bit(1'b0, 2 * BIT_NOM);
    check("ferr_cnt",      ferr_cnt, f0 + 1);
    check("ferr_dat_held", dat, 8'hFF);
    check("ferr_no_vld",   vld_cnt, v0);
    check("ferr_break",    busy, 1'b1);
    line = 1'b1;
    idle(2 * BIT_NOM);
    check("break_exit", busy, 1'b0);
    send_byte(8'h3C, BIT_NOM, 1'b1);
    check("post_ferr_cnt", vld_cnt, v0 + 1);
    check("post_ferr_dat", dat, 8'h3C);
    check("post_ferr_nof", ferr_cnt, f0 + 1);
    idle(200);

    // Reset in the middle of the data bits of 0x81
    v0 = vld_cnt;
    f0 = ferr_cnt;
    drive_bit(1'b0, BIT_NOM);
    drive_bit(1'b1, BIT_NOM);
    drive_bit(1'b0, BIT_NOM / 2);
    check("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mrst_dat",  dat,  8'h00);
    check("mrst_busy", busy, 1'b0);
    check("mrst_vld",  vld,  1'b0);
    check("mrst_ferr", ferr, 1'b0);
    line = 1'b1;
    idle(10);
    rst_n = 1'b1;
    idle(100);
    check("mrst_no_vld",  vld_cnt,  v0);
    check("mrst_no_ferr", ferr_cnt, f0);
    send_byte(8'h7E, BIT_NOM, 1'b1);
    check("mrst_7e_cnt", vld_cnt, v0 + 1);
    check("mrst_7e_dat", dat, 8'h7E);
    idle(200);

    // 0xC3 at +3% and -3% line rate
    send_byte(8'hC3, BIT_FAST, 1'b1);
    check("fast_cnt", vld_cnt, v0 + 2);
    check("fast_dat", vld_datq[vld_datq.size() - 1], 8'hC3);
    idle(200);
    send_byte(8'hC3, BIT_SLOW, 1'b1);
    check("slow_cnt", vld_cnt, v0 + 3);
    check("slow_dat", vld_datq[vld_datq.size() - 1], 8'hC3);
    check("rate_no_ferr", ferr_cnt, f0);
    idle(50);

    check("pulse_width_1", wide_seen, 1'b0);
    check("vld_ferr_excl", both_seen, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
